// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, bus word types and arbiter state encoding
package mem_arb_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after ptr_i wins
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] cand [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_cand
    assign cand[k] = IW'((int'(ptr_i) + k) % NREQ);
  end
  // scan from farthest to nearest so the candidate closest to ptr_i is written last
  always_comb begin
    idx_o = ptr_i;
    for (int k = NREQ - 1; k >= 0; k--) if (req_i[cand[k]]) idx_o = cand[k];
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, lockable sharing of a single-ported word memory among NREQ masters.
// Define MEM_ARB_STATS_EN to build the per-requester grant counters on stat_grants.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_async,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output word_t                    rdata,
  output logic [$clog2(NREQ)-1:0]  owner,
  output addr_t                    mem_address,
  output logic                     mem_write_en,
  output word_t                    mem_write_value,
  input  word_t                    mem_read_value,
  output logic [NREQ*DATA_W-1:0]   stat_grants
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, nxt_owner, pick_ptr, pick_idx;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic access, hold, pick_valid;
  assign nxt_owner = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
  // while busy the search starts just past the owner, so the owner only re-wins when alone
  assign pick_ptr = (state_q == ARB_BUSY) ? nxt_owner : rr_ptr_q;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );
  assign access          = (state_q == ARB_BUSY) && req[owner_q];
  assign hold            = access && req_lock[owner_q] && (int'(hold_cnt_q) < MAX_HOLD - 1);
  assign ack             = access ? NREQ'(1) << owner_q : '0;
  assign rdata           = mem_read_value;
  assign owner           = owner_q;
  assign mem_address     = access ? req_addr[owner_q*ADDR_W +: ADDR_W] : '0;
  assign mem_write_value = access ? req_wdata[owner_q*DATA_W +: DATA_W] : '0;
  assign mem_write_en    = access && req_we[owner_q];
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (hold) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end else begin
      rr_ptr_d   = (state_q == ARB_BUSY) ? nxt_owner : rr_ptr_q;
      hold_cnt_d = (state_q == ARB_BUSY) ? '0 : hold_cnt_q;
      state_d    = pick_valid ? ARB_BUSY : ARB_IDLE;
      owner_d    = pick_valid ? pick_idx : owner_q;
    end
  end
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`ifdef MEM_ARB_STATS_EN
  word_t grants_q [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) grants_q[i] <= '0;
      else if (ack[i]) grants_q[i] <= grants_q[i] + word_t'(1);
    end
    assign stat_grants[i*DATA_W +: DATA_W] = grants_q[i];
  end
`else
  assign stat_grants = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (NREQ=2, MAX_HOLD=4) with a behavioural memory
module tb_mem_port_arbiter;
  localparam int NREQ = 2;
  localparam int MAX_HOLD = 4;
`ifdef MEM_ARB_STATS_EN
  localparam logic [63:0] EXP_STATS = {32'd3, 32'd10};
`else
  localparam logic [63:0] EXP_STATS = 64'd0;
`endif
  typedef struct {
    int          idx;
    logic        we;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  logic clk = 1'b0;
  logic rst_async = 1'b1;
  logic [NREQ-1:0] req = '0, req_we = '0, req_lock = '0, ack;
  logic [NREQ*20-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_wdata = '0, stat_grants;
  logic [31:0] rdata, mem_write_value, mem_read_value;
  logic [19:0] mem_address;
  logic mem_write_en;
  logic [0:0] owner;
  logic [31:0] mem [0:1048575];
  exp_t sb [$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk             (clk),
    .rst_async       (rst_async),
    .req             (req),
    .req_we          (req_we),
    .req_lock        (req_lock),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .ack             (ack),
    .rdata           (rdata),
    .owner           (owner),
    .mem_address     (mem_address),
    .mem_write_en    (mem_write_en),
    .mem_write_value (mem_write_value),
    .mem_read_value  (mem_read_value),
    .stat_grants     (stat_grants)
  );

  assign mem_read_value = mem[mem_address];
  always @(posedge clk) if (mem_write_en) mem[mem_address] <= mem_write_value;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic we, input logic lk,
                         input logic [19:0] a, input logic [31:0] d);
    req[i] = r;
    req_we[i] = we;
    req_lock[i] = lk;
    req_addr[i*20 +: 20] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic push(input int i, input logic we, input logic [19:0] a,
                      input logic [31:0] d, input logic [31:0] rd);
    exp_t e;
    e.idx = i;
    e.we = we;
    e.addr = a;
    e.wdata = d;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_async = 1'b1;
    req = '0;
    req_we = '0;
    req_lock = '0;
    step();
    step();
    rst_async = 1'b0;
  endtask

  // one isolated access: returns cycles from request to ack, -1 if it never came
  task automatic access(input int i, input logic we, input logic [19:0] a,
                        input logic [31:0] d, output int lat);
    push(i, we, a, d, mem[a]);
    set_req(i, 1'b1, we, 1'b0, a, d);
    lat = -1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (ack[i]) lat = c;
    end
    step();
    req[i] = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_async && ack != '0) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 64'(ack), 64'd0);
      end else begin
        e = sb.pop_front();
        check("ack", 64'(ack), 64'(2'b01 << e.idx));
        check("addr", 64'(mem_address), 64'(e.addr));
        check("we", 64'(mem_write_en), 64'(e.we));
        if (e.we) check("wdata", 64'(mem_write_value), 64'(e.wdata));
        else check("rdata", 64'(rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    int lat;
    mem[20'h0000A] = 32'h1000_0000;
    mem[20'h000FF] = 32'h0000_0000;
    mem[20'h00010] = 32'h0A0A_0010;
    mem[20'h00011] = 32'h0B0B_0011;
    mem[20'h00020] = 32'h2020_2020;
    mem[20'h00021] = 32'h2121_2121;
    mem[20'h00030] = 32'h5555_5555;
    mem[20'h00040] = 32'hA0A0_0040;
    mem[20'h00041] = 32'hB1B1_0041;
    step();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_we", 64'(mem_write_en), 64'd0);
    check("rst_stats", stat_grants, 64'd0);

    // single master read then write
    do_reset();
    access(0, 1'b0, 20'h0000A, 32'h0, lat);
    check("t1_rd_lat", 64'(lat), 64'd1);
    access(0, 1'b1, 20'h000FF, 32'h1234_5678, lat);
    check("t1_wr_lat", 64'(lat), 64'd1);
    check("t1_mem", 64'(mem[20'h000FF]), 64'h1234_5678);

    // contention held from reset: alternate 0,1,0,1 with one ack per cycle
    rst_async = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 20'h00040, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 20'h00041, 32'h0);
    for (int k = 0; k < 8; k++)
      push(k % 2, 1'b0, (k % 2) ? 20'h00041 : 20'h00040, 32'h0,
           (k % 2) ? mem[20'h00041] : mem[20'h00040]);
    step();
    rst_async = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("t2_alt", 64'(ack), (c == 0) ? 64'd0 : ((c % 2) ? 64'd1 : 64'd2));
    end
    step();
    req = '0;
    step();

    // locked requester 1 gets MAX_HOLD accesses, then 0 gets one, then the lock run repeats
    do_reset();
    for (int k = 0; k < 10; k++)
      push((k % 5 == 4) ? 0 : 1, 1'b0, (k % 5 == 4) ? 20'h00010 : 20'h00011, 32'h0,
           (k % 5 == 4) ? mem[20'h00010] : mem[20'h00011]);
    set_req(1, 1'b1, 1'b0, 1'b1, 20'h00011, 32'h0);
    @(negedge clk);
    check("t3_idle", 64'(ack), 64'd0);
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 20'h00010, 32'h0);
    for (int c = 1; c < 11; c++) begin
      @(negedge clk);
      check("t3_lock", 64'(ack), (c % 5 == 0) ? 64'd1 : 64'd2);
    end
    step();
    req = '0;
    req_lock = '0;
    step();

    // owner abandons its write: no memory effect, requester 1 served next cycle
    do_reset();
    push(1, 1'b0, 20'h00021, 32'h0, mem[20'h00021]);
    set_req(0, 1'b1, 1'b1, 1'b0, 20'h00020, 32'hBAD0_BAD0);
    set_req(1, 1'b1, 1'b0, 1'b0, 20'h00021, 32'h0);
    @(negedge clk);
    check("t4_idle", 64'(ack), 64'd0);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    check("t4_no_ack", 64'(ack), 64'd0);
    check("t4_no_we", 64'(mem_write_en), 64'd0);
    @(negedge clk);
    check("t4_next", 64'(ack), 64'd2);
    step();
    req = '0;
    step();
    check("t4_mem", 64'(mem[20'h00020]), 64'h2020_2020);

    // asynchronous reset in the middle of an acked write
    do_reset();
    push(1, 1'b1, 20'h00030, 32'hDEAD_BEEF, 32'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 20'h00030, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    check("t5_ack", 64'(ack), 64'd2);
    check("t5_we", 64'(mem_write_en), 64'd1);
    #2 rst_async = 1'b1;
    #1;
    check("t5_rst_we", 64'(mem_write_en), 64'd0);
    check("t5_rst_ack", 64'(ack), 64'd0);
    check("t5_rst_addr", 64'(mem_address), 64'd0);
    check("t5_rst_wval", 64'(mem_write_value), 64'd0);
    check("t5_rst_owner", 64'(owner), 64'd0);
    @(posedge clk);
    #1;
    check("t5_mem", 64'(mem[20'h00030]), 64'h5555_5555);
    req = '0;
    step();
    rst_async = 1'b0;

    // grant counters after 10 CPU and 3 loader accesses
    do_reset();
    for (int k = 0; k < 10; k++) access(0, 1'b0, 20'h00100 + 20'(k), 32'h0, lat);
    check("t6_lat", 64'(lat), 64'd1);
    for (int k = 0; k < 3; k++) access(1, 1'b1, 20'h00200 + 20'(k), 32'(k + 1), lat);
    check("t6_stats", stat_grants, EXP_STATS);
    check("t6_mem", 64'(mem[20'h00202]), 64'd3);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
